// File: rtl/qr_div_seq_if.sv
// qr_div_seq_if: operand and result valid/ready bundle for qr_div_seq.
// master: drives operands and out_ready. slave: the divider.
interface qr_div_seq_if #(
    parameter int inst_a_width = 32,
    parameter int inst_b_width = 16
);
    logic                    in_valid;
    logic                    in_ready;
    logic                    inst_tc;
    logic [inst_a_width-1:0] inst_a;
    logic [inst_b_width-1:0] inst_b;
    logic                    out_valid;
    logic                    out_ready;
    logic [inst_a_width-1:0] quotient;
    logic [inst_b_width-1:0] remainder;
    logic                    div_by_zero;
    logic                    overflow;

    modport master (
        output in_valid, inst_tc, inst_a, inst_b, out_ready,
        input  in_ready, out_valid, quotient, remainder,
        input  div_by_zero, overflow
    );

    modport slave (
        input  in_valid, inst_tc, inst_a, inst_b, out_ready,
        output in_ready, out_valid, quotient, remainder,
        output div_by_zero, overflow
    );
endinterface

// File: rtl/qr_div_seq.sv
// qr_div_seq: sequential restoring divider, signed/unsigned per op.
// Ports: inst_clk, inst_rst_n (async low), bus (qr_div_seq_if.slave).
// QR_DIV_TWO_BITS_EN: retire two quotient bits per CALC cycle.
module qr_div_seq #(
    parameter int inst_a_width = 32,
    parameter int inst_b_width = 16
) (
    input  logic        inst_clk,
    input  logic        inst_rst_n,
    qr_div_seq_if.slave bus
);
    localparam int AW = inst_a_width;
    localparam int BW = inst_b_width;
`ifdef QR_DIV_TWO_BITS_EN
    localparam int STEPS = AW / 2;
`else
    localparam int STEPS = AW;
`endif
    localparam int CW = $clog2(STEPS + 1);
    localparam logic [CW-1:0] LAST = CW'(STEPS - 1);
    localparam logic [AW-1:0] MOST_NEG = {1'b1, {(AW-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
    state_t state, state_n;

    logic          tc_q;
    logic          q_neg;
    logic          r_neg;
    logic [AW-1:0] a_orig;
    logic [BW-1:0] b_orig;
    logic [BW-1:0] b_mag;
    // qa: dividend bits leave at the MSB, quotient bits enter at the LSB
    logic [AW-1:0] qa;
    logic [BW:0]   prem;
    logic [CW-1:0] cnt;
    logic [AW-1:0] q_out;
    logic [BW-1:0] r_out;
    logic          dz_out;
    logic          ov_out;

    function automatic logic [BW+AW:0] step(
        input logic [BW:0]   r,
        input logic [AW-1:0] x,
        input logic [BW-1:0] d
    );
        logic [BW:0] sh;
        logic [BW:0] dd;
        logic        take;
        sh   = {r[BW-1:0], x[AW-1]};
        dd   = {1'b0, d};
        take = (sh >= dd);
        step = {(take ? sh - dd : sh), x[AW-2:0], take};
    endfunction

    logic [BW+AW:0] s1;
    logic [BW+AW:0] s2;

    always_comb begin
        s1 = step(prem, qa, b_mag);
`ifdef QR_DIV_TWO_BITS_EN
        s2 = step(s1[BW+AW:AW], s1[AW-1:0], b_mag);
`else
        s2 = s1;
`endif
    end

    logic sa;
    logic sb;
    assign sa = bus.inst_tc & bus.inst_a[AW-1];
    assign sb = bus.inst_tc & bus.inst_b[BW-1];

    logic          b_zero;
    logic          ov_case;
    logic [AW-1:0] q_fix;
    logic [BW-1:0] r_fix;
    assign b_zero  = (b_orig == '0);
    assign ov_case = tc_q && (a_orig == MOST_NEG) && (&b_orig);
    assign q_fix   = q_neg ? -qa : qa;
    assign r_fix   = (r_neg && prem[BW-1:0] != '0) ?
                     -prem[BW-1:0] : prem[BW-1:0];

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (bus.in_valid)   state_n = CALC;
            CALC:    if (cnt == LAST)    state_n = FIX;
            FIX:                         state_n = DONE;
            DONE:    if (bus.out_ready)  state_n = IDLE;
            default:                     state_n = IDLE;
        endcase
    end

    always_ff @(posedge inst_clk or negedge inst_rst_n) begin
        if (!inst_rst_n) state <= IDLE;
        else             state <= state_n;
    end

    always_ff @(posedge inst_clk or negedge inst_rst_n) begin
        if (!inst_rst_n) begin
            tc_q   <= 1'b0;
            q_neg  <= 1'b0;
            r_neg  <= 1'b0;
            a_orig <= '0;
            b_orig <= '0;
            b_mag  <= '0;
            qa     <= '0;
            prem   <= '0;
            cnt    <= '0;
            q_out  <= '0;
            r_out  <= '0;
            dz_out <= 1'b0;
            ov_out <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (bus.in_valid) begin
                    tc_q   <= bus.inst_tc;
                    a_orig <= bus.inst_a;
                    b_orig <= bus.inst_b;
                    qa     <= sa ? -bus.inst_a : bus.inst_a;
                    b_mag  <= sb ? -bus.inst_b : bus.inst_b;
                    q_neg  <= sa ^ sb;
                    r_neg  <= sa;
                    prem   <= '0;
                    cnt    <= '0;
                end
                CALC: begin
                    prem <= s2[BW+AW:AW];
                    qa   <= s2[AW-1:0];
                    cnt  <= cnt + CW'(1);
                end
                FIX: begin
                    if (b_zero) begin
                        q_out  <= '1;
                        r_out  <= a_orig[BW-1:0];
                        dz_out <= 1'b1;
                        ov_out <= 1'b0;
                    end else if (ov_case) begin
                        q_out  <= MOST_NEG;
                        r_out  <= '0;
                        dz_out <= 1'b0;
                        ov_out <= 1'b1;
                    end else begin
                        q_out  <= q_fix;
                        r_out  <= r_fix;
                        dz_out <= 1'b0;
                        ov_out <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready    = (state == IDLE);
    assign bus.out_valid   = (state == DONE);
    assign bus.quotient    = q_out;
    assign bus.remainder   = r_out;
    assign bus.div_by_zero = dz_out;
    assign bus.overflow    = ov_out;
endmodule
